hdb3_enc_seq: RTL and testbench

- Frame sequencer for the free-running HDB3 encoder chain (V insertion, B insertion, polarity stages). All stages are clocked every cycle with no enable.
- Accepts a frame length and a start pulse, then pulls source bits through a valid/ready handshake.
- Presents exactly one bit per cycle to the encoder. After the last bit it flushes the chain with zeros.
- Tags which encoder output cycles carry frame data, and reports completion and underrun.

---
 rtl/hdb3_enc_seq.sv | 170 +++++++++++++++++
 tb/tb_hdb3_enc_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hdb3_enc_seq.sv
// hdb3_enc_seq: frame sequencer in front of the free-running HDB3 encoder chain.
// Pulls frame bits over a valid/ready handshake and issues exactly one bit per
// RUN cycle. It then flushes the chain with PIPE_LAT zeros and tags the chain
// output cycles that carry frame data.
// Optional build macro HDB3_SEQ_PRBS_EN adds prbs_sel and an internal PRBS-7
// source (x^7+x^6+1, seed 7'h7F) selected per frame at start.
module hdb3_enc_seq #(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             src_valid,
    input  logic             src_data,
`ifdef HDB3_SEQ_PRBS_EN
    input  logic             prbs_sel,
`endif
    output logic             src_ready,
    output logic             enc_bit,
    output logic             sym_valid,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [LEN_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          flush_q, flush_d;
    logic                under_q, under_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic                tag;
    logic                go;       // start accepted this cycle
    logic                prbs_run; // current frame sources from the LFSR
    logic                prbs_bit;

    // abort wins over a simultaneous start
    assign go = (state_q == IDLE) && start && !abort;

`ifdef HDB3_SEQ_PRBS_EN
    logic       prbs_q, prbs_d;
    logic [6:0] lfsr_q, lfsr_d;

    assign prbs_run = prbs_q;
    assign prbs_bit = lfsr_q[6];

    // LFSR: reseed on accepted start, advance once per issued RUN bit
    always_comb begin
        prbs_d = prbs_q;
        lfsr_d = lfsr_q;
        if (go) begin
            prbs_d = prbs_sel;
            lfsr_d = 7'h7F;
        end else if (state_q == RUN && !abort && prbs_q) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prbs_q <= 1'b0;
            lfsr_q <= 7'h7F;
        end else begin
            prbs_q <= prbs_d;
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign prbs_run = 1'b0;
    assign prbs_bit = 1'b0;
`endif

    // next-state and handshake outputs; an abort cycle issues no bit
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        under_d   = under_q;
        tag       = 1'b0;
        src_ready = 1'b0;
        enc_bit   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    cnt_d = '0;
                    if (frame_len == '0) begin
                        state_d = DONE;
                    end else begin
                        len_d   = frame_len;
                        under_d = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    tag       = 1'b1;
                    src_ready = !prbs_run;
                    if (prbs_run) begin
                        enc_bit = prbs_bit;
                    end else begin
                        enc_bit = src_valid & src_data;
                        if (!src_valid) under_d = 1'b1;
                    end
                    // saturating count: RUN is left as soon as len is reached
                    if (cnt_q != len_q) cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        state_d = FLUSH;
                        flush_d = 5'(PIPE_LAT - 1);
                    end
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (flush_q == '0) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // tag travels alongside the bit; abort drops every tag in flight
        if (abort && busy) pipe_d = '0;
        else               pipe_d = (pipe_q << 1) | PIPE_LAT'(tag);
    end

    // sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            under_q <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            under_q <= under_d;
            pipe_q  <= pipe_d;
        end
    end

    assign sym_valid = pipe_q[PIPE_LAT-1];
    assign underrun  = under_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_hdb3_enc_seq.sv
// Randomized bench for hdb3_enc_seq. Expected behaviour is derived per frame
// from the cycle offset relative to the accepted start: RUN covers offsets
// 1..len, FLUSH the next PIPE_LAT, and done follows. Tags appear PIPE_LAT later.
module tb_hdb3_enc_seq;
    localparam int LEN_W    = 16;
    localparam int PIPE_LAT = 8;

    logic             clk = 1'b0;
    logic             rst_n, start, abort, src_valid, src_data;
    logic [LEN_W-1:0] frame_len;
    logic             src_ready, enc_bit, sym_valid, busy, done, underrun;
    logic [LEN_W-1:0] bit_cnt;
`ifdef HDB3_SEQ_PRBS_EN
    logic             prbs_sel = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit ur_exp  = 1'b0;

    hdb3_enc_seq #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .frame_len (frame_len),
        .src_valid (src_valid),
        .src_data  (src_data),
`ifdef HDB3_SEQ_PRBS_EN
        .prbs_sel  (prbs_sel),
`endif
        .src_ready (src_ready),
        .enc_bit   (enc_bit),
        .sym_valid (sym_valid),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one idle cycle with random don't-care inputs
    task automatic idle_cycle();
        @(posedge clk); #1;
        start     = 1'b0;
        abort     = 1'b0;
        frame_len = LEN_W'($urandom);
        src_valid = 1'($urandom);
        src_data  = 1'($urandom);
        @(negedge clk);
    endtask

    // one frame; gap_slot forces src_valid low on that RUN offset,
    // abort_cyc (>0) aborts at that offset, spur re-pulses start mid-frame
    task automatic run_frame(input int len, input int gap_pct, input int gap_slot,
                             input int abort_cyc, input bit spur, input bit prbs);
        bit xs[$];
        int total;
        bit v, d, run, fl;
        xs = {};
        for (int i = 0; i < 7; i++) xs.push_back(1'b1);
        for (int n = 0; xs.size() < len + 1; n++) xs.push_back(xs[n] ^ xs[n+1]);
        total = (len == 0) ? 1 : len + PIPE_LAT + 1;

        @(posedge clk); #1;
        start     = 1'b1;
        abort     = 1'b0;
        frame_len = LEN_W'(len);
        src_valid = 1'($urandom);
        src_data  = 1'($urandom);
`ifdef HDB3_SEQ_PRBS_EN
        prbs_sel  = prbs;
`endif
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(src_ready), 32'd0);
        chk("idle_enc", 32'(enc_bit), 32'd0);
        if (len != 0) ur_exp = 1'b0;

        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            start     = spur && (k == 2 || k == total);
            abort     = (k == abort_cyc);
            frame_len = LEN_W'($urandom);
`ifdef HDB3_SEQ_PRBS_EN
            prbs_sel  = 1'($urandom);
`endif
            v = (k == gap_slot) ? 1'b0 : ($urandom_range(99) >= 32'(gap_pct));
            d = 1'($urandom);
            src_valid = v;
            src_data  = d;
            run = (len != 0) && (k <= len);
            fl  = (len != 0) && (k > len) && (k <= len + PIPE_LAT);
            @(negedge clk);
            chk("busy", 32'(busy), 32'(run | fl));
            chk("src_ready", 32'(src_ready), 32'(run && !prbs));
            chk("enc_bit", 32'(enc_bit), 32'(run ? (prbs ? xs[k-1] : (v & d)) : 1'b0));
            chk("sym_valid", 32'(sym_valid),
                32'((len != 0) && (k >= PIPE_LAT + 1) && (k <= PIPE_LAT + len)));
            chk("done", 32'(done), 32'(k == total));
            chk("bit_cnt", 32'(bit_cnt), run ? 32'(k - 1) : 32'(len));
            if (len != 0) chk("underrun", 32'(underrun), 32'(ur_exp));
            if (run && !prbs && !v) ur_exp = 1'b1;
            if (k == abort_cyc) begin
                for (int j = 0; j < PIPE_LAT + 2; j++) begin
                    idle_cycle();
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_sym", 32'(sym_valid), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_cnt", 32'(bit_cnt), 32'(len));
                end
                return;
            end
        end
        idle_cycle();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_sym", 32'(sym_valid), 32'd0);
        chk("post_cnt", 32'(bit_cnt), 32'(len));
        if (len != 0) chk("post_underrun", 32'(underrun), 32'(ur_exp));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_valid = 1'b0; src_data = 1'b0; frame_len = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sym", 32'(sym_valid), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_enc", 32'(enc_bit), 32'd0);
        chk("rst_under", 32'(underrun), 32'd0);
        chk("rst_cnt", 32'(bit_cnt), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        run_frame(4, 0, 0, 0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0, 1'b0, 1'b0);
        run_frame(6, 0, 3, 0, 1'b0, 1'b0);
        run_frame(5, 0, 0, 5 + 3, 1'b0, 1'b0);
        run_frame(7, 10, 0, 0, 1'b1, 1'b0);
        run_frame(1, 0, 0, 0, 1'b1, 1'b0);
        for (int f = 0; f < 12; f++)
            run_frame(int'($urandom_range(1, 40)), 20, 0, 0, 1'($urandom), 1'b0);

        // start and abort together in IDLE: no frame
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; frame_len = LEN_W'(3);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            idle_cycle();
            chk("sa_busy", 32'(busy), 32'd0);
            chk("sa_done", 32'(done), 32'd0);
        end

        // reset mid-frame while tags are in flight
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; frame_len = LEN_W'(20); src_valid = 1'b1;
        for (int j = 0; j < 11; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_sym", 32'(sym_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sym", 32'(sym_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        run_frame(3, 0, 0, 0, 1'b0, 1'b0);

`ifdef HDB3_SEQ_PRBS_EN
        run_frame(10, 0, 0, 0, 1'b0, 1'b1);
        run_frame(25, 30, 0, 0, 1'b1, 1'b1);
        run_frame(4, 30, 2, 0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
